// File: rtl/simon_score_tracker_if.sv
// Simon score tracker control/display bundle.
// Master drives the game pulses; slave returns the display outputs.
interface simon_score_tracker_if;
    logic       game_start;
    logic       round_pass;
    logic       round_fail;
    logic       show_best_req;
    logic [5:0] result_data;
    logic       display_blank;
    logic       new_best;
    logic       game_over;

    modport master (
        output game_start,
        output round_pass,
        output round_fail,
        output show_best_req,
        input  result_data,
        input  display_blank,
        input  new_best,
        input  game_over
    );

    modport slave (
        input  game_start,
        input  round_pass,
        input  round_fail,
        input  show_best_req,
        output result_data,
        output display_blank,
        output new_best,
        output game_over
    );
endinterface

// File: rtl/simon_score_tracker.sv
// Simon Says score/best tracker driving the 6-bit seven-segment value.
// Blinks after a new best and can briefly show the best score.
module simon_score_tracker #(
    parameter int MAX_SCORE    = 63,
    parameter int FLASH_CYCLES = 25_000_000,
    parameter int SHOW_CYCLES  = 100_000_000
) (
    input logic                  clk,
    input logic                  reset,
    simon_score_tracker_if.slave bus
);
    localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);
    localparam logic [SW-1:0] SHOW_LAST  = SW'(SHOW_CYCLES - 1);
    localparam logic [5:0]    SCORE_MAX  = 6'(MAX_SCORE);

    typedef enum logic [1:0] {
        IDLE,
        PLAYING,
        OVER,
        SHOW_BEST
    } state_t;

    state_t        state_q, state_n;
    logic          ret_over_q, ret_over_n;
    logic [5:0]    score_q, score_n;
    logic [5:0]    best_q, best_n;
    logic          new_best_q, new_best_n;
    logic          blank_q, blank_n;
    logic          game_over_q, game_over_n;
    logic [5:0]    result_q, result_n;
    logic [FW-1:0] blink_q, blink_n;
    logic [SW-1:0] show_q, show_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ret_over_q  <= 1'b0;
            score_q     <= '0;
            best_q      <= '0;
            new_best_q  <= 1'b0;
            blank_q     <= 1'b0;
            game_over_q <= 1'b0;
            result_q    <= '0;
            blink_q     <= '0;
            show_q      <= '0;
        end else begin
            state_q     <= state_n;
            ret_over_q  <= ret_over_n;
            score_q     <= score_n;
            best_q      <= best_n;
            new_best_q  <= new_best_n;
            blank_q     <= blank_n;
            game_over_q <= game_over_n;
            result_q    <= result_n;
            blink_q     <= blink_n;
            show_q      <= show_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        ret_over_n = ret_over_q;
        score_n    = score_q;
        best_n     = best_q;
        new_best_n = new_best_q;
        blank_n    = 1'b0;
        blink_n    = '0;
        show_n     = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.game_start) begin
                    state_n = PLAYING;
                    score_n = '0;
                end else if (bus.show_best_req) begin
                    state_n    = SHOW_BEST;
                    ret_over_n = 1'b0;
                end
            end
            PLAYING: begin
                if (bus.game_start) begin
                    score_n = '0;
                end else if (bus.round_fail) begin
                    state_n = OVER;
                    if (score_q > best_q) begin
                        best_n     = score_q;
                        new_best_n = 1'b1;
                    end
                end else if (bus.round_pass) begin
                    if (score_q != SCORE_MAX)
                        score_n = score_q + 6'd1;
                end
            end
            OVER: begin
                if (bus.game_start) begin
                    state_n    = PLAYING;
                    score_n    = '0;
                    new_best_n = 1'b0;
                end else if (bus.show_best_req) begin
                    state_n    = SHOW_BEST;
                    ret_over_n = 1'b1;
                end else if (new_best_q) begin
                    // Half-period counter; blank flips each time it wraps.
                    if (blink_q == FLASH_LAST) begin
                        blink_n = '0;
                        blank_n = ~blank_q;
                    end else begin
                        blink_n = blink_q + 1'b1;
                        blank_n = blank_q;
                    end
                end
            end
            SHOW_BEST: begin
                if (bus.game_start) begin
                    state_n    = PLAYING;
                    score_n    = '0;
                    new_best_n = 1'b0;
                end else if (bus.show_best_req) begin
                    show_n = '0;
                end else if (show_q == SHOW_LAST) begin
                    state_n = ret_over_q ? OVER : IDLE;
                end else begin
                    show_n = show_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        game_over_n = (state_n == OVER) ||
                      (state_n == SHOW_BEST && ret_over_n);
        result_n    = (state_n == SHOW_BEST) ? best_n : score_n;
    end

    assign bus.result_data   = result_q;
    assign bus.display_blank = blank_q;
    assign bus.new_best      = new_best_q;
    assign bus.game_over     = game_over_q;
endmodule

// File: tb/tb_simon_score_tracker.sv
// Randomised and scenario bench for simon_score_tracker.
// Outputs are compared every cycle against a mode/age reference model.
module tb_simon_score_tracker;
    localparam int F   = 4;
    localparam int S   = 8;
    localparam int MAX = 63;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_OVER = 2;
    localparam int M_SHOW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;

    simon_score_tracker_if bus ();

    simon_score_tracker #(
        .MAX_SCORE   (MAX),
        .FLASH_CYCLES(F),
        .SHOW_CYCLES (S)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int m_mode  = M_IDLE;
    int m_ret   = M_IDLE;
    int m_score = 0;
    int m_best  = 0;
    int m_nb    = 0;
    int m_age   = 0;
    int m_left  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                      tag, got, exp, $time);
    endtask

    task automatic model_step(input bit r, gs, rp, rf, sb);
        if (r) begin
            m_mode = M_IDLE; m_ret = M_IDLE; m_score = 0;
            m_best = 0; m_nb = 0; m_age = 0; m_left = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (gs) begin
                    m_mode = M_PLAY; m_score = 0;
                end else if (sb) begin
                    m_mode = M_SHOW; m_ret = M_IDLE; m_left = S;
                end
            end
            M_PLAY: begin
                if (gs) m_score = 0;
                else if (rf) begin
                    m_mode = M_OVER; m_age = 0;
                    if (m_score > m_best) begin
                        m_best = m_score; m_nb = 1;
                    end
                end else if (rp) m_score = (m_score + 1 > MAX) ? MAX : m_score + 1;
            end
            M_OVER: begin
                if (gs) begin
                    m_mode = M_PLAY; m_score = 0; m_nb = 0;
                end else if (sb) begin
                    m_mode = M_SHOW; m_ret = M_OVER; m_left = S;
                end else m_age++;
            end
            default: begin
                if (gs) begin
                    m_mode = M_PLAY; m_score = 0; m_nb = 0;
                end else if (sb) m_left = S;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = m_ret; m_age = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic cycle(input bit r, gs, rp, rf, sb);
        int exp_blank;
        int exp_go;
        reset             = r;
        bus.game_start    = gs;
        bus.round_pass    = rp;
        bus.round_fail    = rf;
        bus.show_best_req = sb;
        @(posedge clk);
        #1;
        model_step(r, gs, rp, rf, sb);
        exp_blank = (m_mode == M_OVER && m_nb == 1 && ((m_age / F) % 2) == 1) ? 1 : 0;
        exp_go    = (m_mode == M_OVER || (m_mode == M_SHOW && m_ret == M_OVER)) ? 1 : 0;
        chk("result_data", int'(bus.result_data),
            (m_mode == M_SHOW) ? m_best : m_score);
        chk("display_blank", int'(bus.display_blank), exp_blank);
        chk("new_best", int'(bus.new_best), m_nb);
        chk("game_over", int'(bus.game_over), exp_go);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic passes(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1, 0, 0);
    endtask

    initial begin
        bus.game_start    = 1'b0;
        bus.round_pass    = 1'b0;
        bus.round_fail    = 1'b0;
        bus.show_best_req = 1'b0;

        cycle(1, 0, 0, 0, 0);
        chk("reset_result", int'(bus.result_data), 0);

        // pass/fail ignored while idle
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        chk("idle_ignore_go", int'(bus.game_over), 0);

        // first game: new best of 12, blinking
        cycle(0, 1, 0, 0, 0);
        passes(12);
        cycle(0, 0, 0, 1, 0);
        chk("g1_result", int'(bus.result_data), 12);
        chk("g1_new_best", int'(bus.new_best), 1);
        idle(3);
        chk("g1_blank_lo", int'(bus.display_blank), 0);
        idle(1);
        chk("g1_blank_hi", int'(bus.display_blank), 1);
        idle(12);

        // show best from OVER, returns with blink restarted
        cycle(0, 0, 0, 0, 1);
        idle(S + 6);

        // second game: 5, not a best; show_best ignored while playing
        cycle(0, 1, 0, 0, 0);
        passes(2);
        cycle(0, 0, 0, 0, 1);
        chk("play_show_ign", int'(bus.result_data), 2);
        passes(3);
        cycle(0, 0, 0, 1, 0);
        chk("g2_new_best", int'(bus.new_best), 0);
        idle(10);
        cycle(0, 0, 0, 0, 1);
        chk("g2_show_best", int'(bus.result_data), 12);
        idle(3);
        cycle(0, 0, 0, 0, 1);
        idle(S);
        chk("g2_back", int'(bus.result_data), 5);

        // saturation
        cycle(0, 1, 0, 0, 0);
        passes(70);
        chk("sat_result", int'(bus.result_data), 63);
        cycle(0, 0, 0, 1, 0);
        idle(10);

        // pass and fail together at 27
        cycle(0, 1, 0, 0, 0);
        passes(27);
        cycle(0, 0, 1, 1, 0);
        chk("pf_result", int'(bus.result_data), 27);

        // reset mid-game at 35 clears best
        cycle(0, 1, 0, 0, 0);
        passes(35);
        cycle(1, 0, 0, 0, 0);
        chk("midrst_result", int'(bus.result_data), 0);
        cycle(0, 0, 0, 0, 1);
        chk("midrst_best", int'(bus.result_data), 0);
        idle(S);

        // game_start beats show_best_req, and restart from SHOW_BEST
        cycle(0, 1, 0, 0, 1);
        passes(4);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0);
        passes(2);

        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 24) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
